// File: rtl/branch_target_predictor_pkg.sv
// rtl/branch_target_predictor_pkg.sv - shared defaults and counter encodings for the branch target predictor
package branch_target_predictor_pkg;

    localparam int DEF_INDEX_BITS = 5;
    localparam int DEF_TAG_BITS   = 8;
    localparam int DEF_CTR_BITS   = 2;
    localparam int DEF_GSHARE     = 0;

    // Named states of the default 2-bit direction counter
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'd0,
        CTR_WEAK_NT   = 2'd1,
        CTR_WEAK_T    = 2'd2,
        CTR_STRONG_T  = 2'd3
    } ctr2_e;

    // Weak states for an arbitrary counter width: the two values either side of the midpoint
    function automatic int ctr_weak_taken(input int bits);
        return 1 << (bits - 1);
    endfunction

    function automatic int ctr_weak_not_taken(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - lookup, update, flush and statistics bundle of the branch target predictor
interface branch_target_predictor_if
    import branch_target_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) ();

    logic [31:0]           lk_pc;
    logic                  lk_hit;
    logic                  lk_taken;
    logic [31:0]           lk_target;
    logic [INDEX_BITS-1:0] lk_hist;

    logic                  up_valid;
    logic [31:0]           up_pc;
    logic [INDEX_BITS-1:0] up_hist;
    logic                  up_taken;
    logic                  up_pred;
    logic [31:0]           up_target;

    logic                  flush;
    logic [31:0]           stat_lookups;
    logic [31:0]           stat_mispred;

    modport master (
        output lk_pc, up_valid, up_pc, up_hist, up_taken, up_pred, up_target, flush,
        input  lk_hit, lk_taken, lk_target, lk_hist, stat_lookups, stat_mispred
    );

    modport slave (
        input  lk_pc, up_valid, up_pc, up_hist, up_taken, up_pred, up_target, flush,
        output lk_hit, lk_taken, lk_target, lk_hist, stat_lookups, stat_mispred
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - next-state of a saturating up/down direction counter
module sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] value,
    input  logic                inc,
    output logic [CTR_BITS-1:0] next
);

    always_comb begin
        next = value;
        if (inc && (value != {CTR_BITS{1'b1}})) begin
            next = value + 1'b1;
        end else if (!inc && (value != {CTR_BITS{1'b0}})) begin
            next = value - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - tagged BTB with saturating direction counters, bimodal or gshare indexed
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS,
    parameter int CTR_BITS   = DEF_CTR_BITS,
    parameter int GSHARE     = DEF_GSHARE
) (
    input  logic CLK,
    input  logic Reset_L,
    branch_target_predictor_if.slave bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] ghr_q;
    logic [31:0]           lookups_q;
    logic [31:0]           mispred_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  unused_pc_bits;

    // Lookup hashes with the live GHR; updates use the snapshot taken at fetch
    assign lk_idx = bus.lk_pc[INDEX_BITS+1:2] ^ ((GSHARE != 0) ? ghr_q : {INDEX_BITS{1'b0}});
    assign up_idx = bus.up_pc[INDEX_BITS+1:2] ^ ((GSHARE != 0) ? bus.up_hist : {INDEX_BITS{1'b0}});
    assign lk_tag = bus.lk_pc[TAG_HI:TAG_LO];
    assign up_tag = bus.up_pc[TAG_HI:TAG_LO];

    assign unused_pc_bits = ^{bus.lk_pc[1:0], bus.lk_pc[31:TAG_HI+1],
                              bus.up_pc[1:0], bus.up_pc[31:TAG_HI+1]};

    assign bus.lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bus.lk_taken     = bus.lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign bus.lk_target    = bus.lk_hit ? target_q[lk_idx] : (bus.lk_pc + 32'd4);
    assign bus.lk_hist      = ghr_q;
    assign bus.stat_lookups = lookups_q;
    assign bus.stat_mispred = mispred_q;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .value (ctr_q[up_idx]),
        .inc   (bus.up_taken),
        .next  (ctr_next)
    );

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
            ghr_q     <= '0;
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            // Flush takes priority over any entry write in the same cycle
            if (bus.flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (bus.up_valid) begin
                if (up_hit) begin
                    ctr_q[up_idx] <= ctr_next;
                    if (bus.up_taken) begin
                        target_q[up_idx] <= bus.up_target;
                    end
                end else if (bus.up_taken) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= bus.up_target;
                    ctr_q[up_idx]    <= CTR_WEAK_T;
                end
            end

            if (bus.up_valid) begin
                ghr_q <= {ghr_q[INDEX_BITS-2:0], bus.up_taken};
                if (lookups_q != 32'hFFFF_FFFF) begin
                    lookups_q <= lookups_q + 32'd1;
                end
                if ((bus.up_pred != bus.up_taken) && (mispred_q != 32'hFFFF_FFFF)) begin
                    mispred_q <= mispred_q + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5: table has 2**INDEX_BITS entries.
REQ-002 SHALL have parameter TAG_BITS, default 8: tag taken from pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
REQ-003 SHALL have parameter CTR_BITS, default 2: width of the saturating direction counter.
REQ-004 SHALL have parameter GSHARE, default 0: 0 selects bimodal indexing, 1 selects gshare indexing.
REQ-005 SHALL have ports CLK in 1 (clock; all state updates on the falling edge) and Reset_L in 1 (asynchronous active-low reset).
REQ-006 SHALL have lookup ports: lk_pc in 32 (fetch PC); lk_hit out 1; lk_taken out 1; lk_target out 32; lk_hist out INDEX_BITS (GHR snapshot).
REQ-007 SHALL have update ports: up_valid in 1; up_pc in 32; up_hist in INDEX_BITS; up_taken in 1 (actual outcome); up_pred in 1 (prediction made); up_target in 32.
REQ-008 SHALL have ports flush in 1 (invalidate all entries), stat_lookups out 32, and stat_mispred out 32.

Function
REQ-009 Lookup index SHALL be lk_pc[INDEX_BITS+1:2]; when GSHARE=1 it SHALL be XORed with GHR.
REQ-010 Lookup SHALL be combinational, zero latency; lk_hit = entry valid and stored tag equals lk_pc tag.
REQ-011 lk_taken SHALL be lk_hit AND counter MSB; lk_target SHALL be the stored target when lk_hit, else lk_pc+4.
REQ-012 Update index SHALL use up_pc and, when GSHARE=1, up_hist, never the live GHR.
REQ-013 On up_valid with a tag hit: counter increments if up_taken, else decrements; saturates at 0 and 2**CTR_BITS-1; target rewritten when up_taken.
REQ-014 On up_valid with a tag miss and up_taken=1: allocate the entry (valid=1, new tag, target=up_target, counter = weakly-taken 2**(CTR_BITS-1)).
REQ-015 On up_valid with a tag miss and up_taken=0: the entry SHALL NOT change.
REQ-016 On up_valid, the GHR SHALL shift left by one, inserting up_taken at bit 0 (INDEX_BITS wide, oldest bit discarded).
REQ-017 If a lookup and an update hit the same index in the same cycle, lookup SHALL return the pre-update contents.
REQ-018 flush SHALL clear all valid bits at the next falling edge; counters, targets and GHR are retained.
REQ-019 If flush and up_valid occur together, the flush SHALL win and the allocation SHALL be discarded; GHR still shifts.
REQ-020 stat_lookups SHALL increment once per up_valid; stat_mispred SHALL increment when up_valid and up_pred != up_taken; both saturate at 32'hFFFFFFFF and do not wrap.

Reset
REQ-021 Reset_L low SHALL immediately clear all valid bits, GHR, stat_lookups and stat_mispred; counters SHALL be set to weakly-not-taken 2**(CTR_BITS-1)-1 and targets to 0.
REQ-022 During reset, outputs SHALL be: lk_hit=0, lk_taken=0, lk_target=lk_pc+4, lk_hist=0.
REQ-023 A reset asserted mid-update SHALL discard the in-flight update.

Structure
REQ-024 The counter-state encodings and the default parameter values SHALL be placed in a shared package or include file used by the pipeline top level.
REQ-025 The saturating counter SHALL be a sub-module, sat_counter, parameterised by CTR_BITS.
REQ-026 Storage SHALL be flop arrays: valid, tag, target and counter per entry.

Verification
REQ-027 Scenario: after reset, lk_pc=0x00400010 -> lk_hit=0, lk_taken=0, lk_target=0x00400014.
REQ-028 Scenario: update pc=0x00400010, taken, target=0x00400100, then lookup the same pc -> lk_hit=1, lk_taken=1, lk_target=0x00400100.
REQ-029 Scenario: four not-taken updates on the allocated entry -> counter 0, lk_taken=0; one taken update -> counter 1, still not taken.
REQ-030 Scenario: pc 0x00400010 allocated, then lookup of 0x00401010 (same index, different tag) -> lk_hit=0.
REQ-031 Scenario: GSHARE=1, taken updates T,T,N -> lk_hist=5'b00110; lookup index = pc index XOR 5'b00110.
REQ-032 Scenario: 3 updates with up_pred!=up_taken and 2 with a match, then flush -> stat_lookups=5, stat_mispred=3, and all lookups miss.
